// File: rtl/cc_tag_lookup.sv
// Two-stage cache tag lookup: 256-entry valid array, external tag SRAM, hit/miss pulse 2 cycles after a handshake.
// Optional macro CC_TAG_FWD_EN forwards same-index refills into the stage-2 compare.
module cc_tag_lookup (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] tag_i,
  input  logic [7:0]  index_i,
  input  logic [5:0]  offset_i,
  input  logic        hs_pulse_i,
  output logic        tag_rd_en_o,
  output logic [7:0]  tag_raddr_o,
  input  logic [17:0] tag_rdata_i,
  input  logic        fill_valid_i,
  input  logic [7:0]  fill_index_i,
  input  logic [17:0] fill_tag_i,
  output logic        tag_wr_en_o,
  output logic [7:0]  tag_waddr_o,
  output logic [17:0] tag_wdata_o,
  output logic        hit_o,
  output logic        miss_o,
  output logic [7:0]  rsp_index_o,
  output logic [5:0]  rsp_offset_o,
  output logic [31:0] miss_addr_o
);

  assign tag_rd_en_o = hs_pulse_i;
  assign tag_raddr_o = index_i;
  assign tag_wr_en_o = fill_valid_i;
  assign tag_waddr_o = fill_index_i;
  assign tag_wdata_o = fill_tag_i;

  logic [255:0] valid_q;

  // NOTE: the valid array is held in flops rather than SRAM because every entry must clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_valid_i) begin
      valid_q[fill_index_i] <= 1'b1;
    end
  end

  logic        p1_valid;
  logic [17:0] p1_tag;
  logic [7:0]  p1_index;
  logic [5:0]  p1_offset;
  logic        p1_line_valid;
`ifdef CC_TAG_FWD_EN
  logic        p1_fwd;
  logic [17:0] p1_fwd_tag;
`endif

  // NOTE: non-blocking assignment makes valid_q[index_i] sample the pre-fill value on a same-edge fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid      <= 1'b0;
      p1_tag        <= '0;
      p1_index      <= '0;
      p1_offset     <= '0;
      p1_line_valid <= 1'b0;
`ifdef CC_TAG_FWD_EN
      p1_fwd        <= 1'b0;
      p1_fwd_tag    <= '0;
`endif
    end else begin
      p1_valid <= hs_pulse_i;
      if (hs_pulse_i) begin
        p1_tag        <= tag_i;
        p1_index      <= index_i;
        p1_offset     <= offset_i;
        p1_line_valid <= valid_q[index_i];
`ifdef CC_TAG_FWD_EN
        p1_fwd        <= fill_valid_i && (fill_index_i == index_i);
        p1_fwd_tag    <= fill_tag_i;
`endif
      end
    end
  end

  logic        cmp_valid;
  logic [17:0] cmp_tag;
  logic        lookup_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmp_valid = p1_line_valid;
    cmp_tag   = tag_rdata_i;
`ifdef CC_TAG_FWD_EN
    // A refill in the compare cycle is newer than one seen at acceptance, so it is applied last.
    if (p1_fwd) begin
      cmp_valid = 1'b1;
      cmp_tag   = p1_fwd_tag;
    end
    if (fill_valid_i && (fill_index_i == p1_index)) begin
      cmp_valid = 1'b1;
      cmp_tag   = fill_tag_i;
    end
`endif
    lookup_hit = cmp_valid && (cmp_tag == p1_tag);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_o        <= 1'b0;
      miss_o       <= 1'b0;
      rsp_index_o  <= '0;
      rsp_offset_o <= '0;
      miss_addr_o  <= '0;
    end else begin
      hit_o  <= p1_valid && lookup_hit;
      miss_o <= p1_valid && !lookup_hit;
      if (p1_valid) begin
        rsp_index_o  <= p1_index;
        rsp_offset_o <= p1_offset;
        miss_addr_o  <= {p1_tag, p1_index, 6'b0};
      end
    end
  end

endmodule

// File: tb/tb_cc_tag_lookup.sv
// Directed bench for cc_tag_lookup: tag SRAM model, outstanding-lookup queue model, per-cycle compare.
module tb_cc_tag_lookup;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] tag_i = '0;
  logic [7:0]  index_i = '0;
  logic [5:0]  offset_i = '0;
  logic        hs_pulse_i = 1'b0;
  logic        tag_rd_en_o;
  logic [7:0]  tag_raddr_o;
  logic [17:0] tag_rdata_i;
  logic        fill_valid_i = 1'b0;
  logic [7:0]  fill_index_i = '0;
  logic [17:0] fill_tag_i = '0;
  logic        tag_wr_en_o;
  logic [7:0]  tag_waddr_o;
  logic [17:0] tag_wdata_o;
  logic        hit_o;
  logic        miss_o;
  logic [7:0]  rsp_index_o;
  logic [5:0]  rsp_offset_o;
  logic [31:0] miss_addr_o;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  cc_tag_lookup dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tag_i        (tag_i),
    .index_i      (index_i),
    .offset_i     (offset_i),
    .hs_pulse_i   (hs_pulse_i),
    .tag_rd_en_o  (tag_rd_en_o),
    .tag_raddr_o  (tag_raddr_o),
    .tag_rdata_i  (tag_rdata_i),
    .fill_valid_i (fill_valid_i),
    .fill_index_i (fill_index_i),
    .fill_tag_i   (fill_tag_i),
    .tag_wr_en_o  (tag_wr_en_o),
    .tag_waddr_o  (tag_waddr_o),
    .tag_wdata_o  (tag_wdata_o),
    .hit_o        (hit_o),
    .miss_o       (miss_o),
    .rsp_index_o  (rsp_index_o),
    .rsp_offset_o (rsp_offset_o),
    .miss_addr_o  (miss_addr_o)
  );

  // Tag SRAM: synchronous read returning the pre-write contents.
  logic [17:0] sram [256] = '{default: 18'h0};
  logic [17:0] rdata_q = '0;
  always @(posedge clk) begin
    if (tag_wr_en_o) sram[tag_waddr_o] <= tag_wdata_o;
    if (tag_rd_en_o) rdata_q <= sram[tag_raddr_o];
  end
  assign tag_rdata_i = rdata_q;

  // Reference model: outstanding lookups wait in a queue until their compare cycle.
  typedef struct {
    logic [17:0] tag;
    logic [7:0]  idx;
    logic [5:0]  off;
    bit          line_valid;
    logic [17:0] stored;
    bit          fwd;
    logic [17:0] fwd_tag;
  } pend_t;

  pend_t       pend_q[$];
  pend_t       cur;
  bit          mvalid [256];
  bit          m_v;
  logic [17:0] m_t;
  bit          exp_hit = 1'b0;
  bit          exp_miss = 1'b0;
  logic [7:0]  exp_idx = '0;
  logic [5:0]  exp_off = '0;
  logic [31:0] exp_addr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q.delete();
      foreach (mvalid[i]) mvalid[i] = 1'b0;
      exp_hit  = 1'b0;
      exp_miss = 1'b0;
      exp_idx  = '0;
      exp_off  = '0;
      exp_addr = '0;
    end else begin
      exp_hit  = 1'b0;
      exp_miss = 1'b0;
      if (pend_q.size() > 0) begin
        cur = pend_q.pop_front();
        m_v = cur.line_valid;
        m_t = cur.stored;
`ifdef CC_TAG_FWD_EN
        if (cur.fwd) begin
          m_v = 1'b1;
          m_t = cur.fwd_tag;
        end
        if (fill_valid_i && fill_index_i == cur.idx) begin
          m_v = 1'b1;
          m_t = fill_tag_i;
        end
`endif
        exp_hit  = m_v && (m_t == cur.tag);
        exp_miss = !exp_hit;
        exp_idx  = cur.idx;
        exp_off  = cur.off;
        exp_addr = {cur.tag, cur.idx, 6'b0};
      end
      if (hs_pulse_i) begin
        pend_q.push_back('{tag: tag_i, idx: index_i, off: offset_i,
                           line_valid: mvalid[index_i], stored: sram[index_i],
                           fwd: fill_valid_i && (fill_index_i == index_i),
                           fwd_tag: fill_tag_i});
      end
      if (fill_valid_i) mvalid[fill_index_i] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hs_pulse_i   = 1'b0;
    fill_valid_i = 1'b0;
  endtask

  task automatic drive_lookup(input logic [17:0] t, input logic [7:0] i, input logic [5:0] o);
    hs_pulse_i = 1'b1;
    tag_i      = t;
    index_i    = i;
    offset_i   = o;
  endtask

  task automatic drive_fill(input logic [7:0] i, input logic [17:0] t);
    fill_valid_i = 1'b1;
    fill_index_i = i;
    fill_tag_i   = t;
  endtask

  initial begin
    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (!done)
            check("per_cycle {hit,miss,idx,off,addr}",
                  {hit_o, miss_o, rsp_index_o, rsp_offset_o, miss_addr_o},
                  {exp_hit, exp_miss, exp_idx, exp_off, exp_addr});
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {hit_o, miss_o, rsp_index_o, rsp_offset_o, miss_addr_o}, 64'h0);
    rst_n = 1'b1;

    // Cold lookup misses two cycles later; read port mirrors the request.
    drive_lookup(18'h00001, 8'h05, 6'h0A);
    #1;
    check("rd_port", {tag_rd_en_o, tag_raddr_o}, {1'b1, 8'h05});
    @(negedge clk);
    idle();
    check("cold_no_early_pulse", {hit_o, miss_o}, 2'b00);
    @(negedge clk);
    check("cold_miss_flags", {hit_o, miss_o}, 2'b01);
    check("cold_miss_addr", miss_addr_o, 32'h0000_4140);
    check("cold_miss_offset", rsp_offset_o, 6'h0A);

    // Refill then the same lookup hits.
    drive_fill(8'h05, 18'h00001);
    #1;
    check("wr_port", {tag_wr_en_o, tag_waddr_o, tag_wdata_o}, {1'b1, 8'h05, 18'h00001});
    @(negedge clk);
    idle();
    drive_lookup(18'h00001, 8'h05, 6'h3F);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("refill_hit_flags", {hit_o, miss_o}, 2'b10);
    check("refill_hit_rsp", {rsp_index_o, rsp_offset_o}, {8'h05, 6'h3F});

    // Eight back-to-back lookups alternating hit and miss.
    for (int k = 0; k < 4; k++) begin
      drive_fill(8'h10 + 8'(k), 18'h00100 + 18'(k));
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        if (j % 2 == 0) drive_lookup(18'h00100 + 18'(j / 2), 8'h10 + 8'(j / 2), 6'(j));
        else            drive_lookup(18'h00003, 8'h40 + 8'(j), 6'(j));
      end else begin
        idle();
      end
      @(negedge clk);
      if (j >= 1 && j <= 8)
        check($sformatf("b2b_%0d", j - 1), {hit_o, miss_o, rsp_offset_o},
              {((j - 1) % 2 == 0) ? 2'b10 : 2'b01, 6'(j - 1)});
    end
    idle();

    // Fill to the same index one cycle after the lookup is accepted.
    drive_lookup(18'h2AAAA, 8'h22, 6'h01);
    @(negedge clk);
    idle();
    drive_fill(8'h22, 18'h2AAAA);
    @(negedge clk);
    idle();
`ifdef CC_TAG_FWD_EN
    check("fwd_n1_fill", {hit_o, miss_o}, 2'b10);
`else
    check("fwd_n1_fill", {hit_o, miss_o}, 2'b01);
`endif

    // Reset pulled mid-flight discards the lookup and clears valid bits.
    drive_lookup(18'h00001, 8'h05, 6'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    check("rst_flight_0", {hit_o, miss_o, miss_addr_o}, 34'h0);
    @(negedge clk);
    check("rst_flight_1", {hit_o, miss_o, miss_addr_o}, 34'h0);
    rst_n = 1'b1;
    drive_lookup(18'h00001, 8'h05, 6'h02);
    @(negedge clk);
    idle();
    check("post_rst_no_ghost", {hit_o, miss_o}, 2'b00);
    @(negedge clk);
    check("post_rst_miss", {hit_o, miss_o, miss_addr_o}, {2'b01, 32'h0000_4140});

    // Same-cycle lookup and fill on different indices.
    drive_fill(8'h05, 18'h00001);
    @(negedge clk);
    idle();
    drive_lookup(18'h00001, 8'h05, 6'h07);
    drive_fill(8'h30, 18'h00333);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("side_fill_lookup", {hit_o, miss_o, rsp_index_o}, {2'b10, 8'h05});
    drive_lookup(18'h00333, 8'h30, 6'h00);
    @(negedge clk);
    idle();
    @(negedge clk);
    check("side_fill_valid_set", {hit_o, miss_o, rsp_index_o}, {2'b10, 8'h30});

    repeat (2) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
